sqrt_odd_sum_unit: RTL and testbench
====================================

// Module: sqrt_odd_sum_unit
// PURPOSE
//   Iterative integer square root by odd-number summation. It starts with sum=1 and odd=3,
//   then repeats sum+=odd, odd+=2, root+=1 while sum<=radicand.
//   Control FSM plus the update datapath that computes the next value loaded into the
//   low-sum register (reset value 1) and the odd/root registers. One result per start.
// PARAMETERS
//   WIDTH   16   radicand width; must be even, >=4
//   RW      WIDTH/2  root width (localparam, derived)
// PORTS
//   clock      in   1        single clock, rising edge
//   reset      in   1        synchronous, active-low; clears all state
//   start      in   1        request; sampled only in IDLE
//   radicand   in   WIDTH    operand, latched on accepted start
//   busy       out  1        high in ITER and DONE
//   done       out  1        one-cycle pulse, result valid
//   root       out  RW       floor(sqrt(radicand)); held until next completion
// BEHAVIOUR
//   Reset (reset==0 at edge): state=IDLE, busy=0, done=0, root=0, sum=1, odd=3, cnt=0.
//   Internal widths: sum WIDTH+1 bits (reaches 2^WIDTH for max input); odd RW+2 bits;
//     cnt RW bits; n_q WIDTH bits. All adds unsigned, no saturation needed.
//   FSM (Moore outputs):
//     IDLE: start=1 -> latch n_q=radicand, sum=1, odd=3, cnt=0; go ITER. start=0 -> stay.
//     ITER: if sum<=n_q: sum+=odd, odd+=2, cnt+=1, stay.
//           else: root<=cnt, go DONE.
//     DONE: done=1 for exactly this cycle; go IDLE unconditionally.
//   Latency: start sampled at edge E0 -> done high in the cycle after edge E0+root+1.
//     n=0 -> 2 edges to done; n=2^WIDTH-1 -> root=2^RW-1, done after edge E0+2^RW.
//   Comparison uses the full WIDTH+1 sum against zero-extended n_q; no wrap.
//   start while busy: ignored, no queuing; radicand changes while busy: ignored.
//   start in the same cycle as done: not accepted (state DONE); accepted next IDLE cycle.
//   Back-to-back: min issue interval root+3 cycles.
//   root updates only on the ITER->DONE transition; stable otherwise.
//   Reset mid-operation: abort, all outputs to reset values next cycle, no done pulse.
// STRUCTURE
//   Shared package sqrt_pkg: state typedef {IDLE,ITER,DONE} (2-bit), SUM_INIT=1,
//     ODD_INIT=3, ODD_STEP=2.
//   Sub-module sqrt_odd_datapath: sum/odd/cnt/n_q registers, adders, <= comparator.
//     Control inputs: load, step. Output: le_flag (sum<=n_q).
//   Top holds FSM, root register, busy/done decode.
// TESTING
//   n=0: start 1 cycle -> done on 2nd cycle after start, root=0, then busy=0.
//   n=15 then n=16 -> root=3 (done after 4 edges) then root=4 (after 5 edges).
//   n=65535 (WIDTH=16) -> root=255, done exactly 256 edges after start, sum reached 65536.
//   start pulsed every cycle during a run on n=100 -> single done, root=10, no re-entry.
//   reset low mid-run on n=1000 -> next cycle busy=0, done=0, root=0. Then n=1000 gives root=31.
//   Random n sweep vs. model floor(sqrt(n)) -> root and latency root+1 edges match.

Source files
------------

// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared state encoding and init constants for the odd-sum square root
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SUM_INIT = 1;
    localparam int ODD_INIT = 3;
    localparam int ODD_STEP = 2;

endpackage

// File: rtl/sqrt_odd_datapath.sv
// rtl/sqrt_odd_datapath.sv - sum/odd/count registers, adders and sum<=n comparator
module sqrt_odd_datapath
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int RW    = WIDTH / 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] radicand,
    output logic             le_flag,
    output logic [RW-1:0]    cnt
);

    // sum needs one extra bit: it reaches 2^WIDTH on the largest radicand
    logic [WIDTH:0]   sum;
    logic [RW+1:0]    odd;
    logic [WIDTH-1:0] n_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sum <= (WIDTH+1)'(SUM_INIT);
            odd <= (RW+2)'(ODD_INIT);
            cnt <= '0;
            n_q <= '0;
        end else if (load) begin
            sum <= (WIDTH+1)'(SUM_INIT);
            odd <= (RW+2)'(ODD_INIT);
            cnt <= '0;
            n_q <= radicand;
        end else if (step) begin
            sum <= sum + (WIDTH+1)'(odd);
            odd <= odd + (RW+2)'(ODD_STEP);
            cnt <= cnt + 1'b1;
        end
    end

    assign le_flag = (sum <= {1'b0, n_q});

endmodule

// File: rtl/sqrt_odd_sum_unit.sv
// rtl/sqrt_odd_sum_unit.sv - iterative integer square root by odd-number summation
module sqrt_odd_sum_unit
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     radicand,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH/2-1:0]   root
);

    localparam int RW = WIDTH / 2;

    state_t        state;
    state_t        state_next;
    logic          load;
    logic          step;
    logic          le_flag;
    logic [RW-1:0] cnt;

    sqrt_odd_datapath #(
        .WIDTH (WIDTH),
        .RW    (RW)
    ) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .radicand (radicand),
        .le_flag  (le_flag),
        .cnt      (cnt)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ITER;
                end
            end
            ITER: begin
                if (le_flag) begin
                    step = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // root only moves on the ITER->DONE edge so it holds across later runs
    always_ff @(posedge clock) begin
        if (!reset) begin
            root <= '0;
        end else if (state == ITER && !le_flag) begin
            root <= cnt;
        end
    end

    assign busy = (state == ITER) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sqrt_odd_sum_unit.sv
// tb/tb_sqrt_odd_sum_unit.sv - scoreboard bench for sqrt_odd_sum_unit
module tb_sqrt_odd_sum_unit;

    localparam int WIDTH = 16;
    localparam int RW    = WIDTH / 2;

    typedef struct {
        int root;
        int e0;
    } exp_t;

    logic             clock    = 1'b0;
    logic             reset    = 1'b0;
    logic             start    = 1'b0;
    logic [WIDTH-1:0] radicand = '0;
    logic             busy;
    logic             done;
    logic [RW-1:0]    root;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   dones  = 0;
    int   pushed = 0;
    exp_t q[$];

    sqrt_odd_sum_unit #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .radicand (radicand),
        .busy     (busy),
        .done     (done),
        .root     (root)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int isqrt(input int n);
        int k;
        k = 0;
        while ((k + 1) * (k + 1) <= n) k++;
        return k;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset && done === 1'b1) begin
            dones++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("root", int'(root), e.root);
                chk("latency", cyc - e.e0, e.root + 1);
                chk("busy_in_done", int'(busy), 1);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 1000 && busy !== 1'b0; i++) @(negedge clock);
        if (busy !== 1'b0) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input int n, input int exp_root, input bit push);
        exp_t e;
        wait_idle();
        radicand = WIDTH'(n);
        start    = 1'b1;
        if (push) begin
            e.root = exp_root;
            e.e0   = cyc + 1;
            q.push_back(e);
            pushed++;
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    int vec_n   [12] = '{1, 3, 4, 15, 16, 99, 144, 255, 256, 12345, 65024, 65025};
    int vec_root[12] = '{1, 1, 2, 3,  4,  9,  12,  15,  16,  111,   254,   255};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;

        repeat (3) @(negedge clock);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_root", int'(root), 0);
        reset = 1'b1;
        @(negedge clock);

        issue(0, 0, 1);
        wait_idle();
        chk("idle_after_n0", int'(busy), 0);

        for (int i = 0; i < 12; i++) issue(vec_n[i], vec_root[i], 1);
        issue(65535, 255, 1);

        // start held high through a whole run must not cause re-entry
        issue(100, 10, 1);
        guard = 0;
        while (done !== 1'b1 && guard < 1000) begin
            start    = 1'b1;
            radicand = WIDTH'($urandom_range(0, 65535));
            @(negedge clock);
            guard++;
        end
        start = 1'b0;
        if (done !== 1'b1) chk("spam_done_timeout", 1, 0);
        repeat (20) @(negedge clock);
        chk("spam_single_done", dones, pushed);
        chk("spam_idle", int'(busy), 0);

        issue(1000, 31, 0);
        repeat (10) @(negedge clock);
        chk("root_held", int'(root), 10);
        chk("busy_mid_run", int'(busy), 1);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_root", int'(root), 0);
        reset = 1'b1;
        @(negedge clock);
        issue(1000, 31, 1);

        for (int i = 0; i < 6; i++) begin
            n = int'($urandom_range(0, 65535));
            issue(n, isqrt(n), 1);
        end

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clock);
        chk("queue_drained", q.size(), 0);
        repeat (5) @(negedge clock);
        chk("done_count", dones, pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
